// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings and scoreboard entry layout for hazard_scoreboard
package hazard_pkg;
    localparam int MAX_AW = 8;
    localparam int MAX_SW = 4;
    localparam int FWD_RF = 0;
    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;
    localparam int AVAIL_ALU = 1;
    localparam int AVAIL_LOAD = 2;
    typedef struct packed {
        logic v;
        logic we;
        logic [MAX_AW-1:0] wa;
        logic [MAX_SW-1:0] avail;
    } sb_entry_t;
endpackage

// File: rtl/sb_match.sv
// sb_match: youngest scoreboard stage producing one source, in forwarding or stall mode
module sb_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int AW = 4,
    parameter int PC_REG = 15,
    parameter int STALL = 0,
    parameter int SW = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] ent,
    input  logic [AW-1:0]         ra,
    input  logic                  used,
    output logic [SW-1:0]         sel,
    output logic                  hit
);
    // scanning oldest to youngest lets the youngest qualifying producer win
    always_comb begin
        sel = SW'(FWD_RF);
        hit = 1'b0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (used && ent[s].v && ent[s].we && ent[s].wa == MAX_AW'(ra) && int'(ra) != PC_REG &&
                (STALL != 0 ? (s <= DEPTH - 2 && int'(ent[s].avail) > s + 1)
                            : (s > STG_E && int'(ent[s].avail) <= s))) begin
                sel = SW'(s);
                hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-register scoreboard producing forwarding selects, stalls and flushes
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG = 16,
    parameter int NSRC = 2,
    parameter int DEPTH = 3,
    parameter int PC_REG = 15,
    parameter int CNTW = 16,
    parameter int AW = $clog2(NREG),
    parameter int SW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic               issue_we,
    input  logic [AW-1:0]      issue_wa,
    input  logic [SW-1:0]      issue_avail,
    input  logic [NSRC*AW-1:0] dec_ra,
    input  logic [NSRC-1:0]    dec_ra_used,
    input  logic               branch_taken_e,
    output logic               stall_f,
    output logic               stall_d,
    output logic               flush_d,
    output logic               flush_e,
    output logic [NSRC*SW-1:0] fwd_sel,
    output logic [CNTW-1:0]    stall_cnt
);
    sb_entry_t [DEPTH-1:0] ent;
    sb_entry_t nxt;
    logic [NSRC*AW-1:0] e_ra;
    logic [NSRC-1:0] e_used, stall_hit, unused_fwd_hit;
    logic [NSRC*SW-1:0] unused_stall_sel;
    logic load;
    assign load = issue_valid & ~stall_d & ~branch_taken_e;
    always_comb begin
        nxt = '0;
        if (load) nxt = '{v: 1'b1, we: issue_we, wa: MAX_AW'(issue_wa), avail: MAX_SW'(issue_avail)};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent       <= '0;
            e_ra      <= '0;
            e_used    <= '0;
            stall_cnt <= '0;
        end else begin
            ent       <= {ent[DEPTH-2:0], nxt};
            e_ra      <= load ? dec_ra : '0;
            e_used    <= load ? dec_ra_used : '0;
            stall_cnt <= stall_cnt + CNTW'(stall_d && stall_cnt != '1);
        end
    end
    genvar i;
    for (i = 0; i < NSRC; i++) begin : g_src
        sb_match #(.DEPTH(DEPTH), .AW(AW), .PC_REG(PC_REG), .STALL(0)) u_fwd (
            .ent(ent), .ra(e_ra[i*AW +: AW]), .used(e_used[i]),
            .sel(fwd_sel[i*SW +: SW]), .hit(unused_fwd_hit[i])
        );
        sb_match #(.DEPTH(DEPTH), .AW(AW), .PC_REG(PC_REG), .STALL(1)) u_stall (
            .ent(ent), .ra(dec_ra[i*AW +: AW]), .used(dec_ra_used[i]),
            .sel(unused_stall_sel[i*SW +: SW]), .hit(stall_hit[i])
        );
    end
    assign stall_d = |stall_hit & ~branch_taken_e;
    assign stall_f = stall_d;
    assign flush_d = branch_taken_e;
    assign flush_e = branch_taken_e | stall_d;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of forwarding, load-use stalls, branch priority and reset
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset;
    logic issue_valid, issue_we, branch_taken_e;
    logic [3:0] issue_wa;
    logic [1:0] issue_avail;
    logic [7:0] dec_ra;
    logic [1:0] dec_ra_used;
    logic stall_f, stall_d, flush_d, flush_e;
    logic [3:0] fwd_sel;
    logic [1:0] stall_cnt;
    int vectors = 0;
    int miscompares = 0;

    hazard_scoreboard #(.NREG(16), .NSRC(2), .DEPTH(3), .PC_REG(15), .CNTW(2)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_wa(issue_wa), .issue_avail(issue_avail), .dec_ra(dec_ra),
        .dec_ra_used(dec_ra_used), .branch_taken_e(branch_taken_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic iss(input logic v, input logic we, input logic [3:0] wa, input logic [1:0] av,
                       input logic [3:0] ra0, input logic [3:0] ra1, input logic [1:0] used);
        issue_valid = v;
        issue_we = we;
        issue_wa = wa;
        issue_avail = av;
        dec_ra = {ra1, ra0};
        dec_ra_used = used;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        iss(0, 0, 0, 0, 0, 0, 2'b00);
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        branch_taken_e = 1'b0;
        iss(0, 0, 0, 0, 0, 0, 2'b00);
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_fwd", 32'(fwd_sel), 0);
        chk("rst_stall", 32'(stall_d), 0);
        chk("rst_flush_e", 32'(flush_e), 0);
        tick();
        tick();
        reset = 1'b0;
        // ADD r1 then SUB r2,r1,r3 then ADD r6,r1,r1
        iss(1, 1, 1, 1, 2, 3, 2'b00);
        tick();
        iss(1, 1, 2, 1, 1, 3, 2'b11);
        chk("alu_no_stall", 32'(stall_d), 0);
        tick();
        iss(1, 1, 6, 1, 1, 1, 2'b11);
        chk("alu_fwd1", 32'(fwd_sel), 32'h1);
        chk("alu_no_stall2", 32'(stall_d), 0);
        tick();
        iss(0, 0, 0, 0, 0, 0, 2'b00);
        chk("alu_fwd2", 32'(fwd_sel), 32'ha);
        drain();
        // LDR r4 then ADD r5,r4,r4
        iss(1, 1, 4, 2, 0, 0, 2'b00);
        tick();
        iss(1, 1, 5, 1, 4, 4, 2'b11);
        chk("ld_stall_d", 32'(stall_d), 1);
        chk("ld_stall_f", 32'(stall_f), 1);
        chk("ld_flush_e", 32'(flush_e), 1);
        chk("ld_flush_d", 32'(flush_d), 0);
        tick();
        chk("ld_cnt", 32'(stall_cnt), 1);
        chk("ld_stall_clear", 32'(stall_d), 0);
        chk("ld_bubble_fwd", 32'(fwd_sel), 0);
        tick();
        iss(0, 0, 0, 0, 0, 0, 2'b00);
        chk("ld_fwd", 32'(fwd_sel), 32'ha);
        drain();
        // two writers of r1: youngest wins
        iss(1, 1, 1, 1, 0, 0, 2'b00);
        tick();
        tick();
        iss(1, 1, 7, 1, 1, 0, 2'b01);
        chk("young_no_stall", 32'(stall_d), 0);
        tick();
        iss(0, 0, 0, 0, 0, 0, 2'b00);
        chk("youngest", 32'(fwd_sel), 32'h1);
        drain();
        // r15 is never a hazard source
        iss(1, 1, 15, 2, 0, 0, 2'b00);
        tick();
        iss(1, 1, 3, 1, 15, 15, 2'b11);
        chk("pc_stall", 32'(stall_d), 0);
        drain();
        iss(1, 1, 15, 1, 0, 0, 2'b00);
        tick();
        iss(1, 0, 0, 1, 15, 15, 2'b11);
        tick();
        iss(0, 0, 0, 0, 0, 0, 2'b00);
        chk("pc_fwd", 32'(fwd_sel), 0);
        drain();
        // non-writing and invalid producers
        iss(1, 0, 7, 2, 0, 0, 2'b00);
        tick();
        iss(1, 0, 0, 1, 7, 7, 2'b11);
        chk("nowe_stall", 32'(stall_d), 0);
        drain();
        iss(0, 1, 7, 2, 0, 0, 2'b00);
        tick();
        iss(1, 0, 0, 1, 7, 7, 2'b11);
        chk("noval_stall", 32'(stall_d), 0);
        drain();
        iss(1, 0, 7, 1, 0, 0, 2'b00);
        tick();
        iss(1, 0, 0, 1, 7, 7, 2'b11);
        tick();
        iss(0, 0, 0, 0, 0, 0, 2'b00);
        chk("nowe_fwd", 32'(fwd_sel), 0);
        drain();
        // load-use with taken branch in the same cycle
        iss(1, 1, 4, 2, 0, 0, 2'b00);
        tick();
        branch_taken_e = 1'b1;
        iss(1, 1, 5, 1, 4, 4, 2'b11);
        chk("br_stall_d", 32'(stall_d), 0);
        chk("br_stall_f", 32'(stall_f), 0);
        chk("br_flush_d", 32'(flush_d), 1);
        chk("br_flush_e", 32'(flush_e), 1);
        tick();
        branch_taken_e = 1'b0;
        chk("br_cnt", 32'(stall_cnt), 1);
        drain();
        // counter saturates at 3
        for (int k = 0; k < 3; k++) begin
            iss(1, 1, 4, 2, 0, 0, 2'b00);
            tick();
            iss(1, 0, 0, 1, 4, 0, 2'b01);
            chk("sat_stall", 32'(stall_d), 1);
            tick();
            chk("sat_cnt", 32'(stall_cnt), (k == 0) ? 2 : 3);
            tick();
        end
        drain();
        // fill all stages, then reset between edges during a stall
        iss(1, 1, 8, 2, 0, 0, 2'b00);
        tick();
        iss(1, 1, 9, 1, 0, 0, 2'b00);
        tick();
        iss(1, 1, 10, 2, 9, 8, 2'b11);
        chk("fill_no_stall", 32'(stall_d), 0);
        tick();
        iss(1, 1, 11, 1, 10, 0, 2'b01);
        chk("fill_fwd", 32'(fwd_sel), 32'h9);
        chk("fill_stall", 32'(stall_d), 1);
        chk("fill_cnt", 32'(stall_cnt), 3);
        reset = 1'b1;
        #1;
        chk("mid_rst_fwd", 32'(fwd_sel), 0);
        chk("mid_rst_stall", 32'(stall_d), 0);
        chk("mid_rst_flush_e", 32'(flush_e), 0);
        chk("mid_rst_cnt", 32'(stall_cnt), 0);
        tick();
        reset = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
